// File: rtl/uart_rx.sv
// 8N1 UART receiver: MSB-first frames, oversampled by baud_tick_i, writes bytes into a downstream FIFO.
// Optional UART_RX_GLITCH_FILTER_EN adds a 3-sample majority filter ahead of the FSM.
module uart_rx #(
    parameter int DATA_W      = 8,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              baud_tick_i,
    input  logic              rx_i,
    input  logic              full_i,
    output logic              wr_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic                   w_rx;
    logic                   r_prev;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TW-1:0]          r_tick_cnt;
    logic [TW-1:0]          w_tick_nxt;
    logic [BW-1:0]          r_bit_cnt;
    logic [BW-1:0]          w_bit_nxt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      w_shift_nxt;
    logic [DATA_W-1:0]      r_data;
    logic                   r_wr;
    logic                   r_ferr;
    logic                   r_ovr;
    logic                   w_wr_nxt;
    logic                   w_ferr_nxt;
    logic                   w_ovr_nxt;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_GLITCH_FILTER_EN
    // Two stored tick samples plus the live one form the 3-sample majority window.
    logic [1:0] r_filt;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_filt <= 2'b11;
        end else if (baud_tick_i) begin
            r_filt <= {r_filt[0], w_rxs};
        end
    end

    assign w_rx = (w_rxs & r_filt[0]) | (w_rxs & r_filt[1]) | (r_filt[0] & r_filt[1]);
`else
    assign w_rx = w_rxs;
`endif

    // Previous-tick line level resets low so a line held low through reset is not taken as a start edge.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_prev <= 1'b0;
        end else if (baud_tick_i) begin
            r_prev <= w_rx;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_wr_nxt    = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;
        if (baud_tick_i) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx && r_prev) begin
                        w_tick_nxt  = '0;
                        w_state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == TICK_MID) begin
                        if (w_rx) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_tick_nxt  = '0;
                            w_bit_nxt   = '0;
                            w_state_nxt = S_DATA;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_shift_nxt = {r_shift[DATA_W-2:0], w_rx};
                        w_tick_nxt  = '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop lets IDLE catch a start bit that follows with no gap.
                    if (r_tick_cnt == TICK_LAST) begin
                        if (w_rx) begin
                            w_wr_nxt    = !full_i;
                            w_ovr_nxt   = full_i;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (w_rx) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_wr       <= w_wr_nxt;
            r_ferr     <= w_ferr_nxt;
            r_ovr      <= w_ovr_nxt;
            if (w_wr_nxt) begin
                r_data <= r_shift;
            end
        end
    end

    assign wr_o        = r_wr;
    assign rx_data_o   = r_data;
    assign frame_err_o = r_ferr;
    assign overrun_o   = r_ovr;
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against an event-level model.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DATA_W = 8;
    localparam int OVS    = 16;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int LAT = 2 + OVS/2 + OVS*(DATA_W+1);
`else
    localparam int LAT = 1 + OVS/2 + OVS*(DATA_W+1);
`endif
    localparam logic [1:0] EV_WR   = 2'd1;
    localparam logic [1:0] EV_FERR = 2'd2;
    localparam logic [1:0] EV_OVR  = 2'd3;

    logic              sclk = 1'b0;
    logic              rstn = 1'b0;
    logic              baud_tick = 1'b0;
    logic              rx_i = 1'b1;
    logic              full_i = 1'b0;
    logic              wr_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              frame_err_o;
    logic              overrun_o;
    logic              busy_o;

    int total = 0;
    int bad = 0;
    int tick_div = 4;
    int div_cnt = 0;
    int strobe_wide = 0;
    int strobe_overlap = 0;
    logic prev_strobe = 1'b0;
    logic [DATA_W-1:0] model_data = '0;
    logic [DATA_W+1:0] exp_q[$];
    logic [DATA_W+1:0] got_q[$];

    uart_rx dut (
        .sclk        (sclk),
        .rstn        (rstn),
        .baud_tick_i (baud_tick),
        .rx_i        (rx_i),
        .full_i      (full_i),
        .wr_o        (wr_o),
        .rx_data_o   (rx_data_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (div_cnt >= tick_div - 1) div_cnt = 0;
        else div_cnt++;
        baud_tick = (div_cnt == 0);
    end

    always @(negedge sclk) begin
        if (wr_o) got_q.push_back({EV_WR, rx_data_o});
        if (frame_err_o) got_q.push_back({EV_FERR, rx_data_o});
        if (overrun_o) got_q.push_back({EV_OVR, rx_data_o});
        if ((int'(wr_o) + int'(frame_err_o) + int'(overrun_o)) > 1) strobe_overlap++;
        if (prev_strobe && (wr_o || frame_err_o || overrun_o)) strobe_wide++;
        prev_strobe = wr_o || frame_err_o || overrun_o;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge sclk);
            if (baud_tick) k++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] b, input logic stop);
        rx_i = 1'b0;
        wait_ticks(OVS);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            rx_i = b[i];
            wait_ticks(OVS);
        end
        rx_i = stop;
        wait_ticks(OVS);
    endtask

    // Expected outcome of one frame: what the receiver must report and what rx_data_o must show then.
    task automatic model_frame(input logic [DATA_W-1:0] b, input logic stop, input logic full);
        if (!stop) exp_q.push_back({EV_FERR, model_data});
        else if (full) exp_q.push_back({EV_OVR, model_data});
        else begin
            model_data = b;
            exp_q.push_back({EV_WR, b});
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (5) @(negedge sclk);
        total++; if (wr_o !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", wr_o); end
        total++; if (rx_data_o !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
        total++; if (overrun_o !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rstn = 1'b1;
        wait_ticks(6);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_single;
        exp_q.delete(); got_q.delete();
        model_frame(8'hA5, 1'b1, 1'b0);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_ticks(LAT - 1);
                total++; if (wr_o !== 1'b0) begin bad++; $display("FAIL early_wr got=%b exp=0", wr_o); end
                wait_ticks(1);
                total++; if (wr_o !== 1'b1) begin bad++; $display("FAIL latency_wr got=%b exp=1", wr_o); end
                total++; if (rx_data_o !== 8'hA5) begin bad++; $display("FAIL latency_data got=%h exp=a5", rx_data_o); end
            end
        join
        wait_ticks(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back;
        exp_q.delete(); got_q.delete();
        model_frame(8'h00, 1'b1, 1'b0);
        model_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_ticks(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_false_start;
        exp_q.delete(); got_q.delete();
        rx_i = 1'b0;
        wait_ticks(3);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL false_start_busy got=%b exp=1", busy_o); end
        rx_i = 1'b1;
        wait_ticks(12);
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL false_start_idle got=%b exp=0", busy_o); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL false_start_events got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_frame_error;
        exp_q.delete(); got_q.delete();
        model_frame(8'h3C, 1'b0, 1'b0);
        model_frame(8'h81, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0);
        rx_i = 1'b0;
        wait_ticks(40);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL break_busy got=%b exp=1", busy_o); end
        rx_i = 1'b1;
        wait_ticks(8);
        send_frame(8'h81, 1'b1);
        wait_ticks(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ferr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ferr_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overrun;
        exp_q.delete(); got_q.delete();
        model_frame(8'h55, 1'b1, 1'b1);
        full_i = 1'b1;
        send_frame(8'h55, 1'b1);
        full_i = 1'b0;
        wait_ticks(4);
        total++; if (rx_data_o !== model_data) begin bad++; $display("FAIL overrun_hold got=%h exp=%h", rx_data_o, model_data); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL overrun_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL overrun_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [DATA_W-1:0] b;
        b = 8'h96;
        exp_q.delete(); got_q.delete();
        rx_i = 1'b0;
        wait_ticks(OVS);
        for (int i = DATA_W - 1; i >= 4; i--) begin
            rx_i = b[i];
            wait_ticks(OVS);
        end
        rx_i = b[3];
        wait_ticks(OVS/2);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL midframe_busy got=%b exp=1", busy_o); end
        rstn = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b exp=0", busy_o); end
        total++; if (rx_data_o !== 8'h00) begin bad++; $display("FAIL async_reset_data got=%h exp=00", rx_data_o); end
        model_data = '0;
        repeat (3) @(negedge sclk);
        rx_i = 1'b1;
        rstn = 1'b1;
        wait_ticks(20);
        model_frame(8'h96, 1'b1, 1'b0);
        send_frame(8'h96, 1'b1);
        wait_ticks(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rst_mid_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

`ifdef UART_RX_GLITCH_FILTER_EN
    task automatic test_glitch;
        exp_q.delete(); got_q.delete();
        model_frame(8'hFF, 1'b1, 1'b0);
        rx_i = 1'b0;
        wait_ticks(OVS);
        rx_i = 1'b1;
        wait_ticks(57);
        rx_i = 1'b0;
        wait_ticks(1);
        rx_i = 1'b1;
        wait_ticks(86);
        wait_ticks(4);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL glitch_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL glitch_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask
`endif

    task automatic test_random;
        logic [DATA_W-1:0] b;
        logic stop;
        logic full;
        int gap;
        exp_q.delete(); got_q.delete();
        for (int f = 0; f < 20; f++) begin
            tick_div = $urandom_range(1, 4);
            b = DATA_W'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            full = ($urandom_range(0, 3) == 0);
            gap = stop ? $urandom_range(0, 6) : $urandom_range(4, 10);
            model_frame(b, stop, full);
            full_i = full;
            send_frame(b, stop);
            full_i = 1'b0;
            rx_i = 1'b1;
            wait_ticks(gap);
        end
        wait_ticks(4);
        tick_div = 4;
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random_ev%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_strobes;
        total++; if (strobe_wide != 0) begin bad++; $display("FAIL strobe_width got=%0d wide exp=0", strobe_wide); end
        total++; if (strobe_overlap != 0) begin bad++; $display("FAIL strobe_exclusive got=%0d overlaps exp=0", strobe_overlap); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
`ifdef UART_RX_GLITCH_FILTER_EN
        test_glitch();
`endif
        test_random();
        test_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
